// File: rtl/nonce_dispatcher_pkg.sv
// Shared definitions for the nonce dispatcher: FSM states, nonce field size and blob byte-lane mapping.
package nonce_dispatcher_pkg;

  localparam int NONCE_BYTES = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Blob byte k sits at the top of the vector first, so byte 0 occupies the MSBs.
  function automatic int byte_lsb(input int width, input int k);
    return width - 8 * (k + 1);
  endfunction

endpackage

// File: rtl/nonce_dispatcher_nonce_insert.sv
// Combinational overwrite of the little-endian nonce field inside a blob template.
// Zero latency; no flow control of its own.
module nonce_insert #(
  parameter int INPUT_WIDTH  = 2144,
  parameter int NONCE_OFFSET = 39
) (
  input  logic [INPUT_WIDTH-1:0] tmpl_i,
  input  logic [31:0]            nonce_i,
  output logic [INPUT_WIDTH-1:0] data_o
);
  import nonce_dispatcher_pkg::*;

  always_comb begin
    data_o = tmpl_i;
    for (int j = 0; j < NONCE_BYTES; j++) begin
      data_o[byte_lsb(INPUT_WIDTH, NONCE_OFFSET + j) +: 8] = nonce_i[8*j +: 8];
    end
  end

endmodule

// File: rtl/nonce_dispatcher.sv
// Accepts a blob template plus nonce range and streams one nonce-stamped blob per handshake.
// Registered outputs, 1-cycle job-to-first-valid latency, 1 transfer/cycle under continuous ready.
module nonce_dispatcher #(
  parameter int NONCE_WIDTH  = 7,
  parameter int INPUT_WIDTH  = 2144,
  parameter int NONCE_OFFSET = 39
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_job_valid,
  output logic                   o_job_ready,
  input  logic [INPUT_WIDTH-1:0] i_job_data,
  input  logic [31:0]            i_start_nonce,
  input  logic [31:0]            i_nonce_count,
  input  logic                   i_abort,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [NONCE_WIDTH-1:0] o_nonce,
  output logic [INPUT_WIDTH-1:0] o_data,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_aborted,
  output logic [31:0]            o_issued
);
  import nonce_dispatcher_pkg::*;

  state_e                 state_q, state_d;
  logic [INPUT_WIDTH-1:0] tmpl_q, tmpl_d;
  logic [INPUT_WIDTH-1:0] data_q, data_d;
  logic [INPUT_WIDTH-1:0] ins_tmpl, ins_data;
  logic [31:0]            cur_q, cur_d;
  logic [31:0]            rem_q, rem_d;
  logic [31:0]            issued_q, issued_d;
  logic [31:0]            ins_nonce;
  logic [NONCE_WIDTH-1:0] nonce_q, nonce_d;
  logic                   valid_q, valid_d;
  logic                   done_q, done_d;
  logic                   aborted_q, aborted_d;
  logic                   job_acc, xfer, last_xfer, do_abort;

  assign job_acc   = i_job_valid && o_job_ready;
  assign xfer      = valid_q && i_ready;
  assign last_xfer = xfer && (rem_q == 32'd1);
  // A final transfer coinciding with abort is reported as a normal finish.
  assign do_abort  = (state_q == RUN) && i_abort && !last_xfer;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (job_acc && (i_nonce_count != 32'd0)) state_d = RUN;
      RUN:     if (last_xfer || do_abort) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_job_ready = 1'b0;
    o_busy      = 1'b0;
    case (state_q)
      IDLE:    o_job_ready = !done_q;
      RUN:     o_busy      = 1'b1;
      default: ;
    endcase
  end

  // One inserter serves both the first blob of a job and every following nonce.
  assign ins_tmpl  = job_acc ? i_job_data    : tmpl_q;
  assign ins_nonce = job_acc ? i_start_nonce : cur_q + 32'd1;

  nonce_insert #(
    .INPUT_WIDTH  (INPUT_WIDTH),
    .NONCE_OFFSET (NONCE_OFFSET)
  ) u_insert (
    .tmpl_i  (ins_tmpl),
    .nonce_i (ins_nonce),
    .data_o  (ins_data)
  );

  always_comb begin
    tmpl_d    = tmpl_q;
    data_d    = data_q;
    cur_d     = cur_q;
    rem_d     = rem_q;
    issued_d  = issued_q;
    nonce_d   = nonce_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    aborted_d = aborted_q;
    if (job_acc) begin
      tmpl_d    = i_job_data;
      cur_d     = i_start_nonce;
      rem_d     = i_nonce_count;
      issued_d  = 32'd0;
      aborted_d = 1'b0;
      data_d    = ins_data;
      nonce_d   = ins_nonce[NONCE_WIDTH-1:0];
      valid_d   = (i_nonce_count != 32'd0);
      done_d    = (i_nonce_count == 32'd0);
    end else if (state_q == RUN) begin
      if (xfer) begin
        cur_d    = cur_q + 32'd1;
        rem_d    = rem_q - 32'd1;
        issued_d = issued_q + 32'd1;
        data_d   = ins_data;
        nonce_d  = ins_nonce[NONCE_WIDTH-1:0];
      end
      if (last_xfer) begin
        valid_d = 1'b0;
        done_d  = 1'b1;
      end else if (do_abort) begin
        valid_d   = 1'b0;
        done_d    = 1'b1;
        aborted_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmpl_q    <= '0;
      data_q    <= '0;
      cur_q     <= '0;
      rem_q     <= '0;
      issued_q  <= '0;
      nonce_q   <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      tmpl_q    <= tmpl_d;
      data_q    <= data_d;
      cur_q     <= cur_d;
      rem_q     <= rem_d;
      issued_q  <= issued_d;
      nonce_q   <= nonce_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_nonce   = nonce_q;
  assign o_data    = data_q;
  assign o_done    = done_q;
  assign o_aborted = aborted_q;
  assign o_issued  = issued_q;

endmodule

// File: tb/tb_nonce_dispatcher.sv
// Bench for nonce_dispatcher: job table, hand-written corner sequences and a randomized phase
// checked against a transfer-level reference model.
module tb_nonce_dispatcher;
  localparam int NW  = 7;
  localparam int W   = 2144;
  localparam int OFF = 39;

  logic          clk, rst;
  logic          i_job_valid, o_job_ready;
  logic [W-1:0]  i_job_data;
  logic [31:0]   i_start_nonce, i_nonce_count;
  logic          i_abort, o_valid, i_ready;
  logic [NW-1:0] o_nonce;
  logic [W-1:0]  o_data;
  logic          o_busy, o_done, o_aborted;
  logic [31:0]   o_issued;

  nonce_dispatcher #(.NONCE_WIDTH(NW), .INPUT_WIDTH(W), .NONCE_OFFSET(OFF)) dut (
    .clk(clk), .rst(rst), .i_job_valid(i_job_valid), .o_job_ready(o_job_ready),
    .i_job_data(i_job_data), .i_start_nonce(i_start_nonce), .i_nonce_count(i_nonce_count),
    .i_abort(i_abort), .o_valid(o_valid), .i_ready(i_ready), .o_nonce(o_nonce), .o_data(o_data),
    .o_busy(o_busy), .o_done(o_done), .o_aborted(o_aborted), .o_issued(o_issued)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NW-1:0] tag;
    logic [W-1:0]  data;
  } xfer_t;

  typedef struct {
    logic [31:0]   start;
    logic [31:0]   count;
    logic [NW-1:0] exp_tag0;
    logic [31:0]   exp_issued;
  } vec_t;

  xfer_t         exp_q[$];
  xfer_t         m_e;
  int            n_checks = 0;
  int            n_err    = 0;
  logic          stall    = 1'b0;
  logic [W-1:0]  st_data;
  logic [NW-1:0] st_tag;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_data(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    int k;
    n_checks++;
    if (act !== exp) begin
      n_err++;
      k = 0;
      for (int i = W/8 - 1; i >= 0; i--)
        if (act[W-1-8*i -: 8] !== exp[W-1-8*i -: 8]) k = i;
      $display("FAIL %s: byte %0d got %02h expected %02h", nm, k, act[W-1-8*k -: 8], exp[W-1-8*k -: 8]);
    end
  endtask

  function automatic logic [W-1:0] put_nonce(input logic [W-1:0] blob, input logic [31:0] n);
    logic [W-1:0] r;
    r = blob;
    for (int j = 0; j < 4; j++) r[W-1-8*(OFF+j) -: 8] = n[8*j +: 8];
    return r;
  endfunction

  function automatic logic [W-1:0] rand_blob();
    logic [W-1:0] r;
    for (int i = 0; i < W/32; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [31:0] field_bytes(input logic [W-1:0] d);
    return {d[W-1-8*OFF -: 8], d[W-1-8*(OFF+1) -: 8], d[W-1-8*(OFF+2) -: 8], d[W-1-8*(OFF+3) -: 8]};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Every handshake observed must match the next expected {tag, blob}; stalled outputs must hold.
  always @(negedge clk) begin
    if (!rst && o_valid) begin
      if (stall) begin
        chk_data("stall_data", o_data, st_data);
        chk("stall_tag", 64'(o_nonce), 64'(st_tag));
      end
      if (i_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_xfer: got tag %0h required no transfer", o_nonce);
        end else begin
          m_e = exp_q.pop_front();
          chk("xfer_tag", 64'(o_nonce), 64'(m_e.tag));
          chk_data("xfer_data", o_data, m_e.data);
        end
        stall = 1'b0;
      end else begin
        stall   = 1'b1;
        st_data = o_data;
        st_tag  = o_nonce;
      end
    end else begin
      stall = 1'b0;
    end
  end

  task automatic submit(input logic [31:0] s, input logic [31:0] c, input logic [W-1:0] t,
                        output int waited);
    logic [31:0] n;
    xfer_t       x;
    i_job_valid   = 1'b1;
    i_job_data    = t;
    i_start_nonce = s;
    i_nonce_count = c;
    waited = 0;
    while (!o_job_ready && waited < 300) begin
      cyc();
      waited++;
    end
    if (!o_job_ready) begin
      n_checks++;
      n_err++;
      $display("FAIL job_ready_timeout: got 0 after %0d cycles required 1", waited);
    end
    for (int unsigned i = 0; i < c; i++) begin
      n      = s + i;
      x.tag  = n[NW-1:0];
      x.data = put_nonce(t, n);
      exp_q.push_back(x);
    end
    cyc();
    i_job_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (!o_done && n < limit) begin
      cyc();
      n++;
    end
    if (!o_done) begin
      n_checks++;
      n_err++;
      $display("FAIL done_timeout: got no o_done after %0d cycles required a pulse", n);
    end
  endtask

  vec_t        vecs[5];
  int          w, n, m_iss, m_rem;
  logic        fin, m_ab;
  logic [31:0] cnt, st;
  logic        pat[7];

  initial begin
    vecs[0] = '{32'h0000_0010, 32'd3, 7'h10, 32'd3};
    vecs[1] = '{32'hFFFF_FFFE, 32'd3, 7'h7E, 32'd3};
    vecs[2] = '{32'h0000_0000, 32'd1, 7'h00, 32'd1};
    vecs[3] = '{32'h1234_5680, 32'd0, 7'h00, 32'd0};
    vecs[4] = '{32'hABCD_EF7F, 32'd2, 7'h7F, 32'd2};
    pat     = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; i_job_valid = 1'b0; i_job_data = '0; i_start_nonce = '0;
    i_nonce_count = '0; i_abort = 1'b0; i_ready = 1'b0;
    cyc(); cyc();
    chk("rst_job_ready", 64'(o_job_ready), 64'd1);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_issued", 64'(o_issued), 64'd0);
    chk_data("rst_data", o_data, '0);
    rst = 1'b0;
    cyc();

    // Table: full-throughput jobs including wrap, single and zero count.
    i_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      submit(vecs[v].start, vecs[v].count, rand_blob(), w);
      chk("tbl_accept_wait", 64'(w), 64'd0);
      chk("tbl_first_valid", 64'(o_valid), 64'(vecs[v].count != 0));
      if (vecs[v].count != 0) begin
        chk("tbl_first_tag", 64'(o_nonce), 64'(vecs[v].exp_tag0));
        chk("tbl_field", 64'(field_bytes(o_data)),
            64'({vecs[v].start[7:0], vecs[v].start[15:8], vecs[v].start[23:16], vecs[v].start[31:24]}));
      end
      wait_done(200, n);
      chk("tbl_done_latency", 64'(n), 64'(vecs[v].count));
      chk("tbl_issued", 64'(o_issued), 64'(vecs[v].exp_issued));
      chk("tbl_aborted", 64'(o_aborted), 64'd0);
      chk("tbl_valid_low", 64'(o_valid), 64'd0);
      chk("tbl_ready_in_done", 64'(o_job_ready), 64'd0);
      cyc();
      chk("tbl_done_pulse", 64'(o_done), 64'd0);
      chk("tbl_ready_after", 64'(o_job_ready), 64'd1);
    end
    chk("tbl_queue_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure: 4 transfers over a 7-cycle ready pattern.
    submit(32'h0000_0200, 32'd4, rand_blob(), w);
    for (int p = 0; p < 7; p++) begin
      i_ready = pat[p];
      cyc();
      if (p == 2) chk("bp_issued_mid", 64'(o_issued), 64'd1);
    end
    chk("bp_done", 64'(o_done), 64'd1);
    chk("bp_issued", 64'(o_issued), 64'd4);
    i_ready = 1'b1;
    cyc();

    // Abort on the 5th transfer, then immediate new job.
    submit(32'h0000_1000, 32'd100, rand_blob(), w);
    repeat (4) cyc();
    i_abort = 1'b1;
    cyc();
    i_abort = 1'b0;
    chk("ab_valid", 64'(o_valid), 64'd0);
    chk("ab_done", 64'(o_done), 64'd1);
    chk("ab_aborted", 64'(o_aborted), 64'd1);
    chk("ab_issued", 64'(o_issued), 64'd5);
    chk("ab_busy", 64'(o_busy), 64'd0);
    exp_q.delete();
    cyc();
    chk("ab_aborted_held", 64'(o_aborted), 64'd1);
    chk("ab_ready", 64'(o_job_ready), 64'd1);
    submit(32'h0000_2000, 32'd2, rand_blob(), w);
    chk("ab_next_wait", 64'(w), 64'd0);
    chk("ab_cleared", 64'(o_aborted), 64'd0);
    cyc();
    // Abort together with the final transfer is a normal finish.
    i_abort = 1'b1;
    cyc();
    i_abort = 1'b0;
    chk("abfin_done", 64'(o_done), 64'd1);
    chk("abfin_aborted", 64'(o_aborted), 64'd0);
    chk("abfin_issued", 64'(o_issued), 64'd2);
    cyc();

    // Zero count, abort ignored in IDLE, job held high during RUN.
    submit(32'h0000_0077, 32'd0, rand_blob(), w);
    chk("zc_valid", 64'(o_valid), 64'd0);
    chk("zc_done", 64'(o_done), 64'd1);
    chk("zc_issued", 64'(o_issued), 64'd0);
    cyc();
    i_abort = 1'b1;
    cyc();
    i_abort = 1'b0;
    chk("idle_abort_done", 64'(o_done), 64'd0);
    chk("idle_abort_flag", 64'(o_aborted), 64'd0);
    i_ready = 1'b0;
    submit(32'h0000_0300, 32'd3, rand_blob(), w);
    i_job_valid = 1'b1;
    repeat (3) begin
      cyc();
      chk("busy_no_accept", 64'(o_job_ready), 64'd0);
      chk("busy_flag", 64'(o_busy), 64'd1);
    end
    i_ready = 1'b1;
    submit(32'h0000_0400, 32'd2, rand_blob(), w);
    chk("busy_wait", 64'(w), 64'd4);
    wait_done(50, n);
    chk("busy_next_issued", 64'(o_issued), 64'd2);
    cyc();

    // Reset during a stalled run.
    i_ready = 1'b0;
    submit(32'h0000_0500, 32'd5, rand_blob(), w);
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    exp_q.delete();
    chk("mid_rst_valid", 64'(o_valid), 64'd0);
    chk("mid_rst_busy", 64'(o_busy), 64'd0);
    chk("mid_rst_ready", 64'(o_job_ready), 64'd1);
    chk("mid_rst_issued", 64'(o_issued), 64'd0);
    chk("mid_rst_nonce", 64'(o_nonce), 64'd0);
    chk_data("mid_rst_data", o_data, '0);
    i_ready = 1'b1;
    submit(32'h0000_0055, 32'd2, rand_blob(), w);
    chk("post_rst_tag", 64'(o_nonce), 64'h55);
    wait_done(50, n);
    chk("post_rst_issued", 64'(o_issued), 64'd2);
    cyc();

    // Random jobs against a transfer-level model: valid is up for the whole job.
    for (int j = 0; j < 25; j++) begin
      cnt = 32'($urandom_range(1, 10));
      st  = $urandom();
      submit(st, cnt, rand_blob(), w);
      m_iss = 0;
      m_rem = int'(cnt);
      fin   = 1'b0;
      for (int c = 0; c < 200 && !fin; c++) begin
        i_ready = ($urandom_range(0, 3) != 0);
        i_abort = ($urandom_range(0, 15) == 0);
        m_ab = 1'b0;
        if (i_ready) begin
          m_iss++;
          m_rem--;
        end
        if (i_ready && m_rem == 0) fin = 1'b1;
        else if (i_abort) begin
          fin  = 1'b1;
          m_ab = 1'b1;
        end
        cyc();
        chk("rnd_done", 64'(o_done), 64'(fin));
        chk("rnd_valid", 64'(o_valid), 64'(!fin));
        chk("rnd_issued", 64'(o_issued), 64'(m_iss));
        if (fin) chk("rnd_aborted", 64'(o_aborted), 64'(m_ab));
      end
      chk("rnd_finished", 64'(fin), 64'd1);
      i_abort = 1'b0;
      exp_q.delete();
      cyc();
    end

    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
